// File: rtl/fetch_queue.sv
// Instruction fetch queue: a FIFO of {pc, instr, taken} entries between ifetch and decode.
// Define FETCH_QUEUE_BYPASS_EN to let an instruction reach decode in the same cycle while the queue is empty.
module fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [PC_W-1:0]          pc_i,
    input  logic [INSTR_W-1:0]       instr_i,
    input  logic                     taken_i,
    input  logic                     flush_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [PC_W-1:0]          pc_o,
    output logic [INSTR_W-1:0]       instr_o,
    output logic                     taken_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic               taken_mem [DEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;

    logic empty;
    logic bypass;
    logic push;
    logic pop;

    assign empty   = (count == '0);
    assign ready_o = (count != FULL_COUNT);
    assign count_o = count;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty && valid_i && !flush_i;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed instruction consumed by decode this cycle never occupies a slot.
    assign valid_o = !empty || bypass;
    assign pop     = !empty && ready_i && !flush_i;
    assign push    = valid_i && ready_o && !flush_i && !(bypass && ready_i);

    always_comb begin
        pc_o    = pc_mem[head];
        instr_o = instr_mem[head];
        taken_o = taken_mem[head];
        if (bypass) begin
            pc_o    = pc_i;
            instr_o = instr_i;
            taken_o = taken_i;
        end
    end

    // Reset and flush share one path: both discard every entry.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]    <= pc_i;
            instr_mem[tail] <= instr_i;
            taken_mem[tail] <= taken_i;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed vectors plus a long random handshake run.
// The model follows FETCH_QUEUE_BYPASS_EN when the macro is defined for the build.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] pc_i;
    logic [31:0] instr_i;
    logic        taken_i;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        taken_o;
    logic [2:0]  count_o;

    int     total = 0;
    int     bad = 0;
    logic   check_en = 1'b0;
    entry_t mq[$];

    fetch_queue #(.DEPTH(DEPTH), .INSTR_W(32), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .pc_i(pc_i), .instr_i(instr_i), .taken_i(taken_i), .flush_i(flush_i),
        .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o), .instr_o(instr_o),
        .taken_o(taken_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                                 input logic tk, input logic rdy, input logic fl);
        valid_i = v;
        pc_i    = pc;
        instr_i = ins;
        taken_i = tk;
        ready_i = rdy;
        flush_i = fl;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle scoreboard: compare against the model, then advance it as the next edge will.
    logic        prev_stall = 1'b0;
    entry_t      prev_head;
    always @(negedge clk) begin
        if (check_en) begin
            int     n;
            logic   exp_ready;
            logic   exp_bypass;
            logic   exp_valid;
            entry_t exp_head;
            n          = mq.size();
            exp_ready  = (n != DEPTH);
`ifdef FETCH_QUEUE_BYPASS_EN
            exp_bypass = (n == 0) && valid_i && !flush_i;
`else
            exp_bypass = 1'b0;
`endif
            exp_valid  = (n != 0) || exp_bypass;
            exp_head   = (n != 0) ? mq[0] : '{pc: pc_i, instr: instr_i, taken: taken_i};
            checkOutput("mon_ready", 32'(ready_o), 32'(exp_ready));
            checkOutput("mon_valid", 32'(valid_o), 32'(exp_valid));
            checkOutput("mon_count", 32'(count_o), 32'(n));
            if (exp_valid) begin
                checkOutput("mon_pc", pc_o, exp_head.pc);
                checkOutput("mon_instr", instr_o, exp_head.instr);
                checkOutput("mon_taken", 32'(taken_o), 32'(exp_head.taken));
            end
            if (prev_stall) begin
                checkOutput("stall_pc", pc_o, prev_head.pc);
                checkOutput("stall_instr", instr_o, prev_head.instr);
            end
            prev_stall = exp_valid && !ready_i && !flush_i && rst_n;
            prev_head  = exp_head;
            if (!rst_n || flush_i) begin
                mq.delete();
            end else if (exp_bypass) begin
                if (!ready_i) mq.push_back('{pc: pc_i, instr: instr_i, taken: taken_i});
            end else begin
                if (exp_valid && ready_i) void'(mq.pop_front());
                if (valid_i && exp_ready) mq.push_back('{pc: pc_i, instr: instr_i, taken: taken_i});
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check_en = 1'b1;
        checkOutput("reset_count", 32'(count_o), 32'd0);
        checkOutput("reset_valid", 32'(valid_o), 32'd0);
        checkOutput("reset_ready", 32'(ready_o), 32'd1);

        // Single instruction through an empty queue.
        applyStimulus(1'b1, 32'h100, 32'h00000013, 1'b0, 1'b1, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
        checkOutput("single_bypass_valid", 32'(valid_o), 32'd1);
        checkOutput("single_bypass_pc", pc_o, 32'h100);
`endif
        step();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
        checkOutput("single_count", 32'(count_o), 32'd0);
        checkOutput("single_valid_after", 32'(valid_o), 32'd0);
`else
        checkOutput("single_valid", 32'(valid_o), 32'd1);
        checkOutput("single_pc", pc_o, 32'h100);
        checkOutput("single_instr", instr_o, 32'h00000013);
        checkOutput("single_count", 32'(count_o), 32'd1);
`endif
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step();
        checkOutput("single_drained", 32'(count_o), 32'd0);

        // Fill under stall, refuse a fifth, then drain in order.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'(i * 4), 32'h1000 + 32'(i), i[0], 1'b0, 1'b0);
            step();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("full_count", 32'(count_o), 32'd4);
        checkOutput("full_ready", 32'(ready_o), 32'd0);
        applyStimulus(1'b1, 32'h10, 32'h1004, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("fifth_refused", 32'(count_o), 32'd4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
            checkOutput("drain_pc", pc_o, 32'(i * 4));
            checkOutput("drain_instr", instr_o, 32'h1000 + 32'(i));
            step();
        end
        checkOutput("drain_empty", 32'(count_o), 32'd0);

        // Steady push+pop at occupancy two, wrapping the pointers.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 32'h200 + 32'(i * 4), 32'h2000 + 32'(i), 1'b1, 1'b0, 1'b0);
            step();
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'h208 + 32'(i * 4), 32'h2002 + 32'(i), 1'b0, 1'b1, 1'b0);
            checkOutput("wrap_head_pc", pc_o, 32'h200 + 32'(i * 4));
            step();
            checkOutput("wrap_count", 32'(count_o), 32'd2);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("wrap_tail_pc", pc_o, 32'h228);
        step();
        step();
        checkOutput("wrap_drained", 32'(count_o), 32'd0);

        // Flush with a concurrent push.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h300 + 32'(i * 4), 32'h3000, 1'b0, 1'b0, 1'b0);
            step();
        end
        applyStimulus(1'b1, 32'h3fc, 32'h3fff, 1'b1, 1'b1, 1'b1);
        checkOutput("flush_pre_count", 32'(count_o), 32'd3);
        step();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("flush_count", 32'(count_o), 32'd0);
        checkOutput("flush_valid", 32'(valid_o), 32'd0);
        checkOutput("flush_ready", 32'(ready_o), 32'd1);
        step();
        checkOutput("flush_input_absent", 32'(count_o), 32'd0);

        // Reset in the middle of operation.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 32'h400 + 32'(i * 4), 32'h4000, 1'b0, 1'b0, 1'b0);
            step();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("midreset_pre", 32'(count_o), 32'd2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        checkOutput("midreset_count", 32'(count_o), 32'd0);
        checkOutput("midreset_valid", 32'(valid_o), 32'd0);
        checkOutput("midreset_ready", 32'(ready_o), 32'd1);

        // Random handshakes with occasional flushes.
        for (int c = 0; c < 10000; c++) begin
            applyStimulus(1'($urandom_range(1)), $urandom, $urandom, 1'($urandom_range(1)),
                          1'($urandom_range(1)), ($urandom_range(63) == 0));
            step();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) step();
        checkOutput("final_empty", 32'(count_o), 32'd0);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries (power of two, >=2).
REQ-002 SHALL have parameter INSTR_W, default 32, instruction width.
REQ-003 SHALL have parameter PC_W, default 32, PC width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port valid_i  input  1  ifetch presents an instruction.
REQ-007 SHALL have port ready_o  output  1  queue can accept an instruction.
REQ-008 SHALL have port pc_i  input  PC_W  PC of the incoming instruction.
REQ-009 SHALL have port instr_i  input  INSTR_W  incoming instruction word.
REQ-010 SHALL have port taken_i  input  1  ifetch predicted-taken flag.
REQ-011 SHALL have port flush_i  input  1  mispredict/must_flush; discard all contents.
REQ-012 SHALL have port valid_o  output  1  head entry valid toward decode.
REQ-013 SHALL have port ready_i  input  1  decode accepts the head entry.
REQ-014 SHALL have port pc_o  output  PC_W  head PC.
REQ-015 SHALL have port instr_o  output  INSTR_W  head instruction.
REQ-016 SHALL have port taken_o  output  1  head predicted-taken flag.
REQ-017 SHALL have port count_o  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-018 Push SHALL occur when valid_i && ready_o && !flush_i; entry {pc_i, instr_i, taken_i} written at the tail, tail pointer incremented modulo DEPTH.
REQ-019 Pop SHALL occur when valid_o && ready_i && !flush_i; head pointer incremented modulo DEPTH.
REQ-020 ready_o SHALL equal (count_o != DEPTH), derived from registered state only, never from ready_i.
REQ-021 Simultaneous push and pop SHALL leave count_o unchanged; full queue with pop SHALL still deassert ready_o in that cycle.
REQ-022 flush_i SHALL have highest priority: next cycle count_o=0, pointers equal, valid_o=0; a same-cycle push or pop SHALL be ignored.
REQ-023 Without bypass, valid_o SHALL equal (count_o != 0), and pc_o/instr_o/taken_o SHALL show the head entry; minimum latency valid_i to valid_o is 1 cycle.
REQ-024 Output payload SHALL be stable while valid_o=1 and ready_i=0.
REQ-025 Entry order SHALL be strictly FIFO; no entry SHALL be dropped or duplicated except by flush_i.
REQ-026 Payload outputs SHALL be meaningful only when valid_o=1.

Reset
REQ-027 While rst_n=0 at a rising edge: head, tail, count_o SHALL clear to 0; valid_o=0; ready_o=1 from the first cycle after reset release.
REQ-028 Storage array SHALL NOT require reset; reset mid-operation SHALL discard all entries identically to flush.

Configuration
REQ-029 Macro FETCH_QUEUE_BYPASS_EN, when defined: if count_o=0, valid_i=1 and flush_i=0, valid_o SHALL be 1 in the same cycle with payload taken from the inputs; if ready_i=1 that instruction SHALL NOT be stored.
REQ-030 When FETCH_QUEUE_BYPASS_EN is defined and ready_i=0, the bypassed instruction SHALL be pushed normally.
REQ-031 Without FETCH_QUEUE_BYPASS_EN, behaviour SHALL be exactly REQ-023 (registered output, 1-cycle latency).

Verification
REQ-032 Reset, then push pc=0x100 instr=0x00000013 with ready_i=1 -> valid_o=1 next cycle with pc_o=0x100 (same cycle when bypass is enabled), count_o returns to 0.
REQ-033 Hold ready_i=0, push 4 entries pc=0x0,0x4,0x8,0xC -> count_o=4, ready_o=0; 5th valid_i is not accepted; release ready_i -> pops in order 0x0..0xC.
REQ-034 count_o=2, push and pop in the same cycle -> count_o stays 2, order preserved across pointer wrap (run 10 entries).
REQ-035 count_o=3, assert flush_i with valid_i=1 -> next cycle count_o=0, valid_o=0, flushed-cycle input absent.
REQ-036 count_o=2, drive rst_n=0 for one cycle -> count_o=0, valid_o=0, ready_o=1 after release.
REQ-037 Random valid_i/ready_i for 10k cycles against a scoreboard model -> no loss, duplication, or reordering; payload stable under stall.
